tpu_seq_ctrl: RTL and testbench

Job sequencer placed in front of the tpuv1 memory-mapped port. It accepts a start pulse and a 64-bit operand stream, then issues the complete MMIO sequence for one matrix-multiply job. The sequence loads A and B, initialises C, starts the array, waits out the compute window, reads C back, and streams the 16 result words out. It replaces host-driven address sequencing so that a DMA or FIFO can feed the TPU directly.

---
 rtl/tpu_seq_pkg.sv | 28 ++
 rtl/tpu_seq_out_reg.sv | 33 +++
 rtl/tpu_seq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_tpu_seq_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_seq_pkg.sv
// Shared state type, MMIO map and address helper for the tpuv1 job sequencer.
// Optional operand-stream C load is selected by the TPU_SEQ_CLOAD_EN macro.
package tpu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_INIT_C,
    S_GO,
    S_WAIT,
    S_READ_C
  } seq_state_e;

  localparam logic [15:0] A_BASE     = 16'h0100;
  localparam logic [15:0] B_BASE     = 16'h0200;
  localparam logic [15:0] C_BASE     = 16'h0300;
  localparam logic [15:0] START_ADDR = 16'h0400;

  localparam int NUM_AB_WORDS = 8;
  localparam int NUM_C_WORDS  = 16;

  // Word k of a region lives at base + 8k.
  function automatic logic [15:0] calcAddr(input logic [15:0] base, input logic [3:0] idx);
    return base + {9'd0, idx, 3'b000};
  endfunction

endpackage

// File: rtl/tpu_seq_out_reg.sv
// One-entry valid/ready holding register for the result stream.
module tpu_seq_out_reg #(
  parameter int DATAW = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [DATAW-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [DATAW-1:0] o_data
);

  logic             r_valid;
  logic [DATAW-1:0] r_data;

  // A load only arrives when the slot is empty or draining this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/tpu_seq_ctrl.sv
// Job sequencer driving the tpuv1 MMIO port: load A/B, init C, start, wait, read C.
// Define TPU_SEQ_CLOAD_EN to take the 16 C init halves from the operand stream.
module tpu_seq_ctrl #(
  parameter int DIM      = 8,
  parameter int ADDRW    = 16,
  parameter int DATAW    = 64,
  parameter int RD_LAT   = 2,
  parameter int WAIT_CYC = 3*DIM-1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic             tpu_r_w,
  output logic [ADDRW-1:0] tpu_addr,
  output logic [DATAW-1:0] tpu_dataIn,
  input  logic [DATAW-1:0] tpu_dataOut
);
  import tpu_seq_pkg::*;

  localparam logic [3:0] AB_LAST = 4'(NUM_AB_WORDS-1);
  localparam logic [3:0] C_LAST  = 4'(NUM_C_WORDS-1);
  localparam logic [3:0] RD_LAST = 4'(RD_LAT);

  seq_state_e       r_state, w_nextState;
  logic [3:0]       r_idx, r_outCnt, r_rdCnt;
  logic [7:0]       r_waitCnt;
  logic             r_rdActive, r_done;
  logic             r_tpuRw;
  logic [ADDRW-1:0] r_tpuAddr;
  logic [DATAW-1:0] r_tpuDataIn;
  logic             w_inReady, w_inFire, w_abWrite, w_cWrite;
  logic             w_outValid, w_outFire, w_issue, w_capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_cWrite    = 1'b0;
    w_issue     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_nextState = S_LOAD_A;
      S_LOAD_A, S_LOAD_B: begin
        w_inReady = 1'b1;
        if (in_valid && r_idx == AB_LAST)
          w_nextState = (r_state == S_LOAD_A) ? S_LOAD_B : S_INIT_C;
      end
      S_INIT_C: begin
`ifdef TPU_SEQ_CLOAD_EN
        w_inReady = 1'b1;
        w_cWrite  = in_valid;
`else
        w_cWrite  = 1'b1;
`endif
        if (w_cWrite && r_idx == C_LAST) w_nextState = S_GO;
      end
      S_GO:   w_nextState = S_WAIT;
      S_WAIT: if (r_waitCnt == 8'd0) w_nextState = S_READ_C;
      S_READ_C: begin
        // A new read may start as soon as the previous result leaves the output slot.
        w_capture = r_rdActive && (r_rdCnt == RD_LAST);
        w_issue   = !r_rdActive && (!w_outValid || w_outFire);
        if (w_outFire && r_outCnt == C_LAST) begin
          w_nextState = S_IDLE;
          w_issue     = 1'b0;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  assign w_inFire  = in_valid && w_inReady;
  assign w_abWrite = w_inFire && (r_state == S_LOAD_A || r_state == S_LOAD_B);
  assign w_outFire = w_outValid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tpuRw     <= 1'b0;
      r_tpuAddr   <= '0;
      r_tpuDataIn <= '0;
      r_rdActive  <= 1'b0;
      r_rdCnt     <= '0;
    end else begin
      r_tpuRw     <= 1'b0;
      r_tpuAddr   <= '0;
      r_tpuDataIn <= '0;
      if (w_abWrite) begin
        r_tpuRw     <= 1'b1;
        r_tpuAddr   <= calcAddr((r_state == S_LOAD_A) ? A_BASE : B_BASE, r_idx);
        r_tpuDataIn <= in_data;
      end
      if (w_cWrite) begin
        r_tpuRw   <= 1'b1;
        r_tpuAddr <= calcAddr(C_BASE, r_idx);
`ifdef TPU_SEQ_CLOAD_EN
        r_tpuDataIn <= in_data;
`endif
      end
      if (r_state == S_GO) begin
        r_tpuRw   <= 1'b1;
        r_tpuAddr <= START_ADDR;
      end
      if (w_issue) begin
        r_tpuAddr  <= calcAddr(C_BASE, r_idx);
        r_rdActive <= 1'b1;
        r_rdCnt    <= '0;
      end else if (w_capture) begin
        r_rdActive <= 1'b0;
      end else if (r_rdActive) begin
        r_tpuAddr <= r_tpuAddr;
        r_rdCnt   <= r_rdCnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_outCnt  <= '0;
      r_waitCnt <= '0;
      r_done    <= 1'b0;
    end else begin
      if (w_nextState != r_state)                  r_idx <= '0;
      else if (w_abWrite || w_cWrite || w_capture) r_idx <= r_idx + 4'd1;

      if (r_state == S_IDLE) r_outCnt <= '0;
      else if (w_outFire)    r_outCnt <= r_outCnt + 4'd1;

      if (r_state == S_GO)                         r_waitCnt <= 8'(WAIT_CYC-1);
      else if (r_state == S_WAIT && r_waitCnt != 8'd0) r_waitCnt <= r_waitCnt - 8'd1;

      r_done <= (r_state == S_READ_C) && (w_nextState == S_IDLE);
    end
  end

  tpu_seq_out_reg #(.DATAW(DATAW)) u_outReg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_capture),
    .i_data  (tpu_dataOut),
    .i_ready (out_ready),
    .o_valid (w_outValid),
    .o_data  (out_data)
  );

  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign in_ready   = w_inReady;
  assign out_valid  = w_outValid;
  assign tpu_r_w    = r_tpuRw;
  assign tpu_addr   = r_tpuAddr;
  assign tpu_dataIn = r_tpuDataIn;

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for tpu_seq_ctrl with a behavioural TPU memory stub.
module tb_tpu_seq_ctrl;

  localparam int WAIT_CYC = 23;

`ifdef TPU_SEQ_CLOAD_EN
  localparam int NWORDS = 32;
  localparam bit CLOAD  = 1'b1;
`else
  localparam int NWORDS = 16;
  localparam bit CLOAD  = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [63:0] in_data = '0;
  logic        busy, done, in_ready, out_valid, tpu_r_w;
  logic [63:0] out_data, tpu_dataIn, tpu_dataOut;
  logic [15:0] tpu_addr;

  always #5 clk = ~clk;

  tpu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr), .tpu_dataIn(tpu_dataIn),
    .tpu_dataOut(tpu_dataOut)
  );

  int checks = 0, errors = 0, cyc = 0;
  logic [79:0] expWr[$];
  logic [63:0] expOut[$];
  int doneSeen = 0, outIdx = 0, bpWord = -1, bpCnt = 0;
  int opA[8][8], opB[8][8], opC[8][8];
  logic [63:0] stream[32];

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  always @(posedge clk) cyc++;

  // TPU stub: a small memory map plus a matrix multiply on the start write.
  logic [63:0] aMem[8], bMem[8], cMem[16];
  logic [63:0] rdPipe1 = '0, rdPipe2 = '0;
  assign tpu_dataOut = rdPipe2;

  function automatic logic [63:0] tpuRead(input logic [15:0] a);
    if (a >= 16'h300 && a < 16'h380 && a[2:0] == 3'b000) return cMem[a[6:3]];
    return 64'hBAD0_BAD1_BAD2_BAD3;
  endfunction

  task automatic tpuCompute();
    logic [63:0] nc[16];
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 8; j++) begin
        int acc;
        acc = int'($signed(cMem[2*r + j/4][16*(j%4) +: 16]));
        for (int k = 0; k < 8; k++)
          acc += int'($signed(aMem[r][8*k +: 8])) * int'($signed(bMem[k][8*j +: 8]));
        nc[2*r + j/4][16*(j%4) +: 16] = acc[15:0];
      end
    for (int k = 0; k < 16; k++) cMem[k] = nc[k];
  endtask

  always @(posedge clk) begin
    rdPipe1 <= tpuRead(tpu_addr);
    rdPipe2 <= rdPipe1;
    if (tpu_r_w) begin
      if (tpu_addr >= 16'h100 && tpu_addr < 16'h140)      aMem[tpu_addr[5:3]] = tpu_dataIn;
      else if (tpu_addr >= 16'h200 && tpu_addr < 16'h240) bMem[tpu_addr[5:3]] = tpu_dataIn;
      else if (tpu_addr >= 16'h300 && tpu_addr < 16'h380) cMem[tpu_addr[6:3]] = tpu_dataIn;
      else if (tpu_addr == 16'h400)                      tpuCompute();
    end
  end

  // Monitors: MMIO writes, result stream, done pulse, wait window.
  logic        prevStall = 1'b0, armed = 1'b0;
  logic [63:0] prevData = '0;
  int          goCyc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prevStall = 1'b0;
      armed     = 1'b0;
    end else begin
      if (tpu_r_w) begin
        if (expWr.size() == 0) checkOutput("strayWrite", {tpu_addr, tpu_dataIn}, 80'h0);
        else checkOutput("mmioWrite", {tpu_addr, tpu_dataIn}, expWr.pop_front());
        if (tpu_addr == 16'h400) begin
          goCyc = cyc;
          armed = 1'b1;
        end
      end else if (armed && tpu_addr == 16'h300) begin
        checkOutput("firstReadDelay", 80'(cyc - goCyc), 80'(WAIT_CYC + 1));
        armed = 1'b0;
      end
      if (prevStall) begin
        checkOutput("outHold", {15'd0, out_valid, out_data}, {15'd0, 1'b1, prevData});
        checkOutput("noReadInStall", {64'd0, tpu_addr}, 80'd0);
      end
      if (out_valid && out_ready) begin
        if (expOut.size() == 0) checkOutput("strayOut", {16'd0, out_data}, 80'h0);
        else checkOutput("outData", {16'd0, out_data}, {16'd0, expOut.pop_front()});
        outIdx++;
      end
      prevStall = out_valid && !out_ready;
      prevData  = out_data;
      if (done) begin
        checkOutput("doneWhileIdle", {79'd0, busy}, 80'd0);
        doneSeen++;
      end
    end
  end

  // Result-side backpressure: hold out_ready low for 10 cycles on word bpWord.
  initial forever begin
    @(posedge clk);
    #1;
    if (out_valid && outIdx == bpWord && bpCnt < 10) begin
      out_ready = 1'b0;
      bpCnt++;
    end else begin
      out_ready = 1'b1;
    end
  end

  task automatic buildJob(input bit identity);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        if (identity) begin
          opA[r][c] = (r == c) ? 1 : 0;
          opB[r][c] = r + 1;
          opC[r][c] = CLOAD ? 1 : 0;
        end else begin
          opA[r][c] = int'($urandom_range(0, 255)) - 128;
          opB[r][c] = int'($urandom_range(0, 255)) - 128;
          opC[r][c] = CLOAD ? int'($urandom_range(0, 4000)) - 2000 : 0;
        end
      end
    for (int r = 0; r < 8; r++) begin
      logic [63:0] wa, wb;
      for (int c = 0; c < 8; c++) begin
        wa[8*c +: 8] = opA[r][c][7:0];
        wb[8*c +: 8] = opB[r][c][7:0];
      end
      stream[r]     = wa;
      stream[8 + r] = wb;
    end
    for (int k = 0; k < 16; k++) begin
      logic [63:0] wc;
      for (int m = 0; m < 4; m++) wc[16*m +: 16] = opC[k/2][(k%2)*4 + m][15:0];
      stream[16 + k] = wc;
    end
  endtask

  task automatic pushExpected();
    for (int k = 0; k < 8; k++) expWr.push_back({16'h100 + 16'(8*k), stream[k]});
    for (int k = 0; k < 8; k++) expWr.push_back({16'h200 + 16'(8*k), stream[8 + k]});
    for (int k = 0; k < 16; k++) expWr.push_back({16'h300 + 16'(8*k), CLOAD ? stream[16 + k] : 64'h0});
    expWr.push_back({16'h400, 64'h0});
    for (int k = 0; k < 16; k++) begin
      logic [63:0] w;
      for (int m = 0; m < 4; m++) begin
        int r, c, sum;
        logic [31:0] t;
        r = k / 2;
        c = (k % 2) * 4 + m;
        sum = opC[r][c];
        for (int i = 0; i < 8; i++) sum += opA[r][i] * opB[i][c];
        t = sum;
        w[16*m +: 16] = t[15:0];
      end
      expOut.push_back(w);
    end
  endtask

  task automatic pulseStart();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feedWords(input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      int guard;
      in_data  = stream[i];
      in_valid = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        reportTimeout("inReady");
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (toggle) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input bit identity, input bit toggle, input int bpSel, input bit startInWait);
    int n;
    buildJob(identity);
    pushExpected();
    doneSeen = 0;
    outIdx   = 0;
    bpCnt    = 0;
    bpWord   = bpSel;
    pulseStart();
    feedWords(NWORDS, toggle);
    if (startInWait) begin
      repeat (20) @(posedge clk);
      #1;
      start = 1'b1;
      checkOutput("busyInWait", {79'd0, busy}, 80'd1);
      @(posedge clk); #1;
      start = 1'b0;
    end
    n = 0;
    while (!(doneSeen > 0 && expOut.size() == 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) reportTimeout("jobDone");
    repeat (5) @(negedge clk);
    checkOutput("writesLeft", 80'(expWr.size()), 80'd0);
    checkOutput("doneCount", 80'(doneSeen), 80'd1);
    checkOutput("idleAfterJob", {79'd0, busy}, 80'd0);
    expWr.delete();
    expOut.delete();
    bpWord = -1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "Flags"}, {75'd0, busy, done, in_ready, out_valid, tpu_r_w}, 80'd0);
    checkOutput({tag, "OutData"}, {16'd0, out_data}, 80'd0);
    checkOutput({tag, "TpuAddr"}, {64'd0, tpu_addr}, 80'd0);
    checkOutput({tag, "TpuDataIn"}, {16'd0, tpu_dataIn}, 80'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Abort a job in LOAD_B, then confirm a clean restart.
    buildJob(1'b0);
    pushExpected();
    pulseStart();
    feedWords(11, 1'b0);
    checkOutput("busyInLoadB", {79'd0, busy}, 80'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkResetOutputs("midJobReset");
    expWr.delete();
    expOut.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] identity job");
    applyStimulus(1'b1, 1'b0, -1, 1'b0);
    $display("[TB] random job, input stalls");
    applyStimulus(1'b0, 1'b1, -1, 1'b0);
    $display("[TB] random job, output backpressure on word 5");
    applyStimulus(1'b0, 1'b0, 5, 1'b0);
    $display("[TB] random job, start during wait, mixed stalls");
    applyStimulus(1'b0, 1'b1, 2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
